// File: rtl/branch_history_table.sv
// Direct-mapped branch history table with target buffer.
// Provides fetch-stage prediction, execute-stage training and perf counters.
module branch_history_table #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        ex_mispredict,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        NTS = 2'b00,
        NTW = 2'b01,
        TW  = 2'b10,
        TS  = 2'b11
    } ctr_t;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    ctr_t             ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] rd_idx;
    logic [TAG_W-1:0]      rd_tag;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [TAG_W-1:0]      wr_tag;
    logic                  wr_hit;
    logic                  unused_bits;

    assign rd_idx      = if_pc[INDEX_BITS+1:2];
    assign rd_tag      = if_pc[31:INDEX_BITS+2];
    assign wr_idx      = ex_pc[INDEX_BITS+1:2];
    assign wr_tag      = ex_pc[31:INDEX_BITS+2];
    assign wr_hit      = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign unused_bits = ^{if_pc[1:0], ex_pc[1:0]};

    function automatic ctr_t next_ctr(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        unique case (cur)
            NTS: nxt = taken ? NTW : NTS;
            NTW: nxt = taken ? TS  : NTS;
            TW:  nxt = taken ? TS  : NTS;
            TS:  nxt = taken ? TS  : TW;
            default: nxt = NTS;
        endcase
        return nxt;
    endfunction

    always_comb begin
        pred_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        pred_taken  = pred_hit && ctr_q[rd_idx][1];
        pred_target = pred_hit ? target_q[rd_idx] : 32'd0;
    end

    assign ex_mispredict = ex_valid &&
        ((ex_taken != ex_pred_taken) ||
         (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= NTS;
            end
        end else if (ex_valid) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= next_ctr(ctr_q[wr_idx], ex_taken);
                if (ex_taken) begin
                    target_q[wr_idx] <= ex_target;
                end
            end else if (ex_taken) begin
                // A taken miss evicts whatever alias occupied the slot
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= ex_target;
                ctr_q[wr_idx]    <= NTW;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches    <= 32'd0;
            perf_mispredicts <= 32'd0;
        end else begin
            if (ex_valid) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (ex_mispredict) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end

endmodule
